ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Companion to the existing PS/2 keyboard receive path. Shares the PS2_CLK/PS2_DATA pins through open-drain enables.
- Game control logic drives it with a start/busy/done handshake.
- The receive path ignores the bus while tx_busy is high.

Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit length in iCLK_50 cycles (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum gap before the first device clock edge, and between device clock edges (15 ms).
- MAX_RETRY, 2: automatic retries after an error; used only with PS2_TX_RETRY_EN.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- tx_start  in  1  one-cycle request; accepted only when tx_busy=0.
- tx_data  in  8  command byte; latched on accept.
- tx_busy  out  1  high from accept until the done/err cycle.
- tx_done  out  1  one-cycle pulse: frame sent and device acknowledged.
- tx_err  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_data_in  in  1  raw PS2_DATA pin level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release.

Behaviour:
- Reset: state IDLE; all outputs 0; shift register, bit counter and timer cleared.
- Asserting reset mid-frame releases both lines immediately, with no done or err pulse.
- Pin synchronisation: 2-flop synchroniser on each pin. A third flop on the clock gives fall = prev & ~sync.
- Edge latency: 3 cycles from pin change to fall.
- Frame: 11 bits, built at accept:
  - start = 0
  - D0..D7, LSB first
  - parity = ~^tx_data (odd parity)
  - stop = 1
- IDLE:
  - tx_start & ~tx_busy: latch data, set tx_busy, go to INHIBIT.
  - tx_start while busy is ignored.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe=1 asserted in the last cycle (start bit).
  - Then go to SHIFT.
- SHIFT:
  - ps2_clk_oe=0; ps2_data_oe stays 1 (start bit driven).
  - Falling edge k (k=1..10) presents frame bit k (D0..D7, parity, stop): ps2_data_oe = ~bit, applied the cycle after fall.
  - After the 10th edge the data line is released; go to ACK.
- ACK:
  - On the 11th falling edge, sample synchronised data.
  - Sample 0: go to WAIT_IDLE.
  - Sample 1: go to ERR.
- WAIT_IDLE:
  - Wait until synchronised clk=1 and data=1.
  - Then pulse tx_done, deassert tx_busy, go to IDLE.
- Timer:
  - Cleared on entry to SHIFT and on every falling edge.
  - Reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE goes to ERR.
- ERR: both oe=0, pulse tx_err, deassert tx_busy, return to IDLE.
- Handshake timing:
  - done/err and busy=0 are registered together.
  - tx_start in the following cycle is accepted.
- Falling edges seen during INHIBIT are ignored, since the host is driving the clock.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On error, the block restarts INHIBIT with the same byte, up to MAX_RETRY times.
  - tx_busy stays high throughout.
  - tx_err pulses only after the final failure.
  - tx_done pulses on any success.
- Undefined: first error ends the transfer with a tx_err pulse; no retry counter is present.

Test Plan:
Bench parameters: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200; device model clocks at a 40-cycle period and acks by default.
1. Send 0xED, device acks:
   - ps2_clk_oe high for exactly 10 cycles.
   - Device samples 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity=1, stop).
   - One tx_done pulse; tx_err=0.
2. Send 0x07: parity sampled=0. Send 0x00: parity sampled=1. Both complete with tx_done.
3. Device never clocks after inhibit: tx_err pulses 200 cycles after SHIFT entry; both oe=0; tx_busy=0.
4. Device leaves data high on the 11th edge: tx_err pulses and no tx_done (macro undefined). With PS2_TX_RETRY_EN and the device failing every time: 3 inhibit phases, then one tx_err.
5. tx_start pulsed mid-frame with 0x55: ignored, and the frame keeps the original byte. Then assert reset mid-SHIFT: oe outputs go 0 asynchronously, busy=0, no pulses.
6. tx_start in the cycle after tx_done: the new byte is accepted and INHIBIT begins the next cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 11-bit frame on device clock, check ack.
// Optional macro PS2_TX_RETRY_EN: on error, re-send the same byte up to MAX_RETRY times before flagging tx_err.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       iCLK_50,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned TW        = $clog2(TIMER_MAX + 1);
    localparam int unsigned FRAME_W   = 11;
    localparam int unsigned CW        = 4;
`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RW        = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        SHIFT     = 3'd2,
        ACK       = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 clk_oe_d, data_oe_d, busy_d, done_d, err_d;
    logic                 fail;
`ifdef PS2_TX_RETRY_EN
    logic [RW-1:0]        retry_q, retry_d;
`endif

    // Pin synchronisers; the third clock flop gives the falling-edge detect
    logic clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic fall;

    always_ff @(posedge iCLK_50 or posedge reset) begin
        if (reset) begin
            clk_meta  <= 1'b0;
            clk_sync  <= 1'b0;
            clk_prev  <= 1'b0;
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge iCLK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            tx_busy     <= busy_d;
            tx_done     <= done_d;
            tx_err      <= err_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs are registered from the _d values
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        busy_d    = tx_busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_start && !tx_busy) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data, 1'b0};
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = '0;
`endif
                end
            end
            INHIBIT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                timer_d = timer_q + TW'(1);
                if (fall) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    data_oe_d = ~frame_q[bit_cnt_d];
                    if (bit_cnt_d == CW'(FRAME_W - 1)) state_d = ACK;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            ACK: begin
                timer_d   = timer_q + TW'(1);
                data_oe_d = 1'b0;
                if (fall) begin
                    timer_d = '0;
                    if (data_sync) fail = 1'b1;
                    else           state_d = WAIT_IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                timer_d = timer_q + TW'(1);
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Error path: release the bus, then either retry or report
        if (fail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            timer_d   = '0;
            bit_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != RW'(MAX_RETRY)) begin
                retry_d  = retry_q + RW'(1);
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
            end else begin
                busy_d  = 1'b0;
                err_d   = 1'b1;
                state_d = IDLE;
            end
`else
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus with a device model clocking at a 40-cycle period.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    logic       ps2_clk_in, ps2_data_in;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt, err_cnt, inhibit_cnt, oe_run, last_oe_len;
    logic oe_prev = 1'b0;

    always #10 clk = ~clk;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(10),
        .TIMEOUT_CYCLES(200),
        .MAX_RETRY(2)
    ) dut (
        .iCLK_50(clk),
        .reset(reset),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Pulse and inhibit-phase monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
        if (ps2_clk_oe && !oe_prev) inhibit_cnt++;
        if (ps2_clk_oe) oe_run++;
        else if (oe_prev) begin
            last_oe_len = oe_run;
            oe_run = 0;
        end
        oe_prev = ps2_clk_oe;
    end

    task automatic clear_counts();
        @(posedge clk);
        done_cnt = 0; err_cnt = 0; inhibit_cnt = 0; oe_run = 0; last_oe_len = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        tx_data  = b;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    // Device side: wait for request-to-send, sample each bit in the clock-high phase, optionally ack
    task automatic device_frame(input logic ack, output logic [10:0] samp);
        int n;
        samp = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2_clk_oe && n < 200);
        if (ps2_clk_oe) begin
            vectors++; miscompares++;
            $display("FAIL device_rts: clk_oe=%b required 0", ps2_clk_oe);
        end
        for (int k = 0; k < 11; k++) begin
            repeat (10) @(negedge clk);
            samp[k] = ps2_data_in;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        while (tx_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) begin
            vectors++; miscompares++;
            $display("FAIL %s_busy_timeout: busy=%b required 0", name, tx_busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (tx_busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b want 0", tx_done); end
        vectors++; if (tx_err !== 1'b0)      begin miscompares++; $display("FAIL reset_err: got %b want 0", tx_err); end
        vectors++; if (ps2_clk_oe !== 1'b0)  begin miscompares++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        vectors++; if (ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ed();
        logic [10:0] s;
        clear_counts();
        send(8'hED);
        device_frame(1'b1, s);
        wait_not_busy("ed");
        vectors++; if (last_oe_len !== 10) begin miscompares++; $display("FAIL ed_inhibit_len: got %0d want 10", last_oe_len); end
        vectors++; if (s !== 11'b111_1101_1010) begin miscompares++; $display("FAIL ed_bits: got %b want 11111011010", s); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL ed_done: got %0d want 1", done_cnt); end
        vectors++; if (err_cnt !== 0)  begin miscompares++; $display("FAIL ed_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_parity();
        logic [10:0] s;
        clear_counts();
        send(8'h07);
        device_frame(1'b1, s);
        wait_not_busy("p07");
        vectors++; if (s !== 11'b100_0000_1110) begin miscompares++; $display("FAIL p07_bits: got %b want 10000001110", s); end
        send(8'h00);
        device_frame(1'b1, s);
        wait_not_busy("p00");
        vectors++; if (s !== 11'b110_0000_0000) begin miscompares++; $display("FAIL p00_bits: got %b want 11000000000", s); end
        vectors++; if (done_cnt !== 2) begin miscompares++; $display("FAIL parity_done: got %0d want 2", done_cnt); end
        vectors++; if (err_cnt !== 0)  begin miscompares++; $display("FAIL parity_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        clear_counts();
        send(8'hFF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2_clk_oe && n < 100);
        vectors++; if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL to_start_bit: data_oe=%b want 1", ps2_data_oe); end
        n = 0;
        while (!tx_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n !== 200) begin miscompares++; $display("FAIL to_latency: got %0d want 200", n); end
        vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin miscompares++; $display("FAIL to_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_nack();
        logic [10:0] s;
        clear_counts();
        send(8'hED);
`ifdef PS2_TX_RETRY_EN
        for (int a = 0; a < 3; a++) device_frame(1'b0, s);
`else
        device_frame(1'b0, s);
`endif
        repeat (30) @(negedge clk);
        vectors++; if (err_cnt !== 1)  begin miscompares++; $display("FAIL nack_err: got %0d want 1", err_cnt); end
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL nack_done: got %0d want 0", done_cnt); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL nack_busy: got %b want 0", tx_busy); end
`ifdef PS2_TX_RETRY_EN
        vectors++; if (inhibit_cnt !== 3) begin miscompares++; $display("FAIL nack_inhibits: got %0d want 3", inhibit_cnt); end
`else
        vectors++; if (inhibit_cnt !== 1) begin miscompares++; $display("FAIL nack_inhibits: got %0d want 1", inhibit_cnt); end
`endif
    endtask

    task automatic test_busy_ignore();
        logic [10:0] s;
        clear_counts();
        send(8'h3C);
        fork
            device_frame(1'b1, s);
            begin
                repeat (60) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_not_busy("ign");
        repeat (20) @(negedge clk);
        vectors++; if (s !== 11'b110_0111_1000) begin miscompares++; $display("FAIL ign_bits: got %b want 11001111000", s); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL ign_done: got %0d want 1", done_cnt); end
        vectors++; if (inhibit_cnt !== 1) begin miscompares++; $display("FAIL ign_inhibits: got %0d want 1", inhibit_cnt); end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        clear_counts();
        send(8'h12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2_clk_oe && n < 100);
        repeat (5) @(negedge clk);
        @(posedge clk); #5;
        reset = 1'b1;
        #1;
        vectors++; if (ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
        vectors++; if (ps2_clk_oe !== 1'b0)  begin miscompares++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
        vectors++; if (tx_busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        vectors++; if ((done_cnt + err_cnt) !== 0) begin miscompares++; $display("FAIL rst_pulses: got %0d want 0", done_cnt + err_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] s;
        int n;
        clear_counts();
        send(8'h07);
        device_frame(1'b1, s);
        n = 0;
        while (!tx_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (tx_done !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done: got %b want 1", tx_done); end
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        @(negedge clk);
        vectors++; if (tx_busy !== 1'b1)    begin miscompares++; $display("FAIL b2b_busy: got %b want 1", tx_busy); end
        vectors++; if (ps2_clk_oe !== 1'b1) begin miscompares++; $display("FAIL b2b_inhibit: got %b want 1", ps2_clk_oe); end
        device_frame(1'b1, s);
        wait_not_busy("b2b");
        vectors++; if (s !== 11'b111_1111_1110) begin miscompares++; $display("FAIL b2b_bits: got %b want 11111111110", s); end
        vectors++; if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
    endtask

    initial begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        test_reset();
        test_send_ed();
        test_parity();
        test_timeout();
        test_nack();
        test_busy_ignore();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
